// File: rtl/line_follower_pkg.sv
// ---------------------------------------------------------------------------
// line_follower_pkg
// Shared definitions for the line-follower path logic: node-ID width, number
// of slots in the planner path word, the "before start" sentinel ID and the
// path sequencer state enumeration.
// No ports (package).
// ---------------------------------------------------------------------------
package line_follower_pkg;

    localparam int NODE_W     = 5;
    localparam int PATH_SLOTS = 10;
    localparam int SENTINEL   = 27;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        TRAVEL,
        DONE
    } seq_state_t;

endpackage

// File: rtl/path_len_scan.sv
// ---------------------------------------------------------------------------
// path_len_scan
// Combinational scan of a planner path word. Finds the lowest slot holding
// the sentinel (k), or PATH_SLOTS when none does, and flags the path as bad
// when any node ID below that slot is out of range.
// Ports:
//   path_word : input,  PATH_SLOTS*NODE_W bits, slot i at [i*NODE_W +: NODE_W]
//   k         : output, index of first sentinel slot (PATH_SLOTS if absent)
//   bad       : output, a slot below k holds an ID >= SENTINEL
// ---------------------------------------------------------------------------
module path_len_scan #(
    parameter int NODE_W     = line_follower_pkg::NODE_W,
    parameter int PATH_SLOTS = line_follower_pkg::PATH_SLOTS,
    parameter int SENTINEL   = line_follower_pkg::SENTINEL,
    parameter int KW         = $clog2(PATH_SLOTS + 1)
) (
    input  logic [PATH_SLOTS*NODE_W-1:0] path_word,
    output logic [KW-1:0]                k,
    output logic                         bad
);
    import line_follower_pkg::*;

    // Walk the slots from the end node upward. Until the first sentinel is
    // met every slot belongs to the path, so any ID above the sentinel seen
    // before it marks the path as bad; slots past the sentinel are don't-care.
    always_comb begin
        logic found;
        logic [NODE_W-1:0] s;
        k     = KW'(PATH_SLOTS);
        bad   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < PATH_SLOTS; i++) begin
            s = path_word[i*NODE_W +: NODE_W];
            if (!found) begin
                if (s == NODE_W'(SENTINEL)) begin
                    found = 1'b1;
                    k     = KW'(i);
                end else if (s > NODE_W'(SENTINEL)) begin
                    bad = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/path_sequencer.sv
// ---------------------------------------------------------------------------
// path_sequencer
// Turns a planner path word into a sequence of move commands for the motor
// controller, one edge at a time, advancing on each node_reached pulse.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   path_valid, path_in   : planner done level and packed path word
//   abort                 : cancel the current path (highest priority)
//   move_valid/move_ready : move command handshake
//   move_from, move_to    : edge to traverse
//   node_reached          : arrival pulse from line sensing
//   cur_node              : last node reached
//   busy                  : high whenever not IDLE
//   path_done, path_err   : one-cycle completion / rejection pulses
// ---------------------------------------------------------------------------
module path_sequencer #(
    parameter int NODE_W     = line_follower_pkg::NODE_W,
    parameter int PATH_SLOTS = line_follower_pkg::PATH_SLOTS,
    parameter int SENTINEL   = line_follower_pkg::SENTINEL
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         path_valid,
    input  logic [PATH_SLOTS*NODE_W-1:0] path_in,
    input  logic                         abort,
    output logic                         move_valid,
    input  logic                         move_ready,
    output logic [NODE_W-1:0]            move_from,
    output logic [NODE_W-1:0]            move_to,
    input  logic                         node_reached,
    output logic [NODE_W-1:0]            cur_node,
    output logic                         busy,
    output logic                         path_done,
    output logic                         path_err
);
    import line_follower_pkg::*;

    localparam int KW = $clog2(PATH_SLOTS + 1);

    seq_state_t                   state;
    logic                         pv_q;
    logic                         pv_armed;
    logic                         pv_rise;
    logic [PATH_SLOTS*NODE_W-1:0] path_q;
    logic [KW-1:0]                idx;
    logic [KW-1:0]                scan_k;
    logic                         scan_bad;

    function automatic logic [NODE_W-1:0] slot(input logic [PATH_SLOTS*NODE_W-1:0] w,
                                               input logic [KW-1:0] i);
        return w[int'(i)*NODE_W +: NODE_W];
    endfunction

    path_len_scan #(
        .NODE_W    (NODE_W),
        .PATH_SLOTS(PATH_SLOTS),
        .SENTINEL  (SENTINEL),
        .KW        (KW)
    ) u_scan (
        .path_word(path_q),
        .k        (scan_k),
        .bad      (scan_bad)
    );

    // Rising-edge detector for the planner done level. The armed flag only
    // sets once path_valid has been seen low, so a level that is still high
    // when reset releases cannot masquerade as a fresh path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q     <= 1'b0;
            pv_armed <= 1'b0;
        end else begin
            pv_q     <= path_valid;
            pv_armed <= pv_armed | ~path_valid;
        end
    end

    assign pv_rise = path_valid & ~pv_q & pv_armed;
    assign busy    = (state != IDLE);

    // Main sequencer. Abort wins over everything and leaves cur_node alone.
    // In TRAVEL the node being reached is always the current move_to, and
    // the next edge starts from it, so the following move_from is simply
    // the old move_to. The completion and error pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            path_q     <= '0;
            idx        <= '0;
            cur_node   <= '0;
            move_valid <= 1'b0;
            move_from  <= '0;
            move_to    <= '0;
            path_done  <= 1'b0;
            path_err   <= 1'b0;
        end else begin
            path_done <= 1'b0;
            path_err  <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                move_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pv_rise) begin
                            path_q <= path_in;
                            state  <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (scan_k == '0 || scan_bad) begin
                            path_err <= 1'b1;
                            state    <= IDLE;
                        end else if (scan_k == KW'(1)) begin
                            cur_node  <= slot(path_q, '0);
                            path_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx        <= scan_k - KW'(1);
                            cur_node   <= slot(path_q, scan_k - KW'(1));
                            move_from  <= slot(path_q, scan_k - KW'(1));
                            move_to    <= slot(path_q, scan_k - KW'(2));
                            move_valid <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (move_ready) begin
                            move_valid <= 1'b0;
                            state      <= TRAVEL;
                        end
                    end
                    TRAVEL: begin
                        if (node_reached) begin
                            cur_node <= move_to;
                            idx      <= idx - KW'(1);
                            if (idx == KW'(1)) begin
                                path_done <= 1'b1;
                                state     <= DONE;
                            end else begin
                                move_from  <= move_to;
                                move_to    <= slot(path_q, idx - KW'(2));
                                move_valid <= 1'b1;
                                state      <= ISSUE;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
